// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : dmem_arb_pkg                                                |
// | Purpose : Shared state encoding and default geometry for the          |
// |           data-memory arbiter slice.                                  |
// | Contents: state_t (IDLE/ACCESS), default DEPTH/AW/DW/NREQ constants.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package dmem_arb_pkg;

  localparam int c_depth_default = 128;
  localparam int c_aw_default    = 32;
  localparam int c_dw_default    = 32;
  localparam int c_nreq_default  = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : dmem_arbiter_if                                           |
// | Purpose   : Bundles the requester-side handshake and the memory-side  |
// |             bus of the data-memory arbiter.                           |
// | Modports  : slave  - the arbiter (takes requests, drives memory)      |
// |             master - requesters plus memory (drive requests/mem_dout)|
// | Signals   : req/we_i/adr_i/din_i  per-requester request fields        |
// |             gnt/rvalid/rdata/err  per-requester responses             |
// |             mem_we/mem_adr/mem_din/mem_dout  memory port              |
// | Revision  : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int AW   = c_aw_default,
  parameter int DW   = c_dw_default
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we_i;
  logic [NREQ*AW-1:0] adr_i;
  logic [NREQ*DW-1:0] din_i;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               mem_we;
  logic [AW-1:0]      mem_adr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout;

  modport slave (
    input  req, we_i, adr_i, din_i, mem_dout,
    output gnt, rvalid, rdata, err, mem_we, mem_adr, mem_din
  );

  modport master (
    output req, we_i, adr_i, din_i, mem_dout,
    input  gnt, rvalid, rdata, err, mem_we, mem_adr, mem_din
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rr_arbiter                                                  |
// | Purpose : Combinational round-robin pick. Searches req starting at    |
// |           index ptr, wrapping around, and returns a one-hot grant.    |
// | Ports   : req   [NREQ] request vector                                 |
// |           ptr   [PW]   index with highest priority this round         |
// |           grant [NREQ] one-hot winner (all zero when req is zero)     |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic w_found;

  // Two passes: first the indices at or above ptr, then the wrapped ones
  // below it. This gives the rotated priority without a barrel shifter.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j >= int'(ptr))) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j < int'(ptr))) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : dmem_arbiter                                                |
// | Purpose : Round-robin arbiter sharing one data memory between NREQ    |
// |           requesters (index 0 = CPU). Each access takes one IDLE      |
// |           arbitration cycle and one ACCESS cycle.                     |
// | Ports   : clk    clock, rising edge                                   |
// |           rst_n  asynchronous active-low reset                        |
// |           bus    dmem_arbiter_if.slave (requests, responses, memory)  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = c_depth_default,
  parameter int AW    = c_aw_default,
  parameter int DW    = c_dw_default,
  parameter int NREQ  = c_nreq_default
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int           PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]  c_depth = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] c_last = PW'(NREQ - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic            r_we;
  logic            r_in_range;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_win;
  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_din;
  logic            w_we;
  logic            w_in_range;
  logic            w_start;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (bus.req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Steer the winning requester's fields out of the packed request buses.
  always_comb begin
    w_win = '0;
    w_adr = '0;
    w_din = '0;
    w_we  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_win = PW'(j);
        w_adr = bus.adr_i[j*AW +: AW];
        w_din = bus.din_i[j*DW +: DW];
        w_we  = bus.we_i[j];
      end
    end
  end

  assign w_in_range = ({1'b0, w_adr} < c_depth);
  assign w_start    = (r_state == ST_IDLE) && (|bus.req);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (|bus.req) w_state_next = ST_ACCESS;
      ST_ACCESS: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // All response/strobe outputs are flops so nothing on the memory or
  // requester side sees a combinational path from req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_we        <= 1'b0;
      r_in_range  <= 1'b0;
      bus.gnt     <= '0;
      bus.rvalid  <= '0;
      bus.err     <= 1'b0;
      bus.rdata   <= '0;
      bus.mem_we  <= 1'b0;
      bus.mem_adr <= '0;
      bus.mem_din <= '0;
    end else begin
      r_state    <= w_state_next;
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      bus.err    <= 1'b0;
      bus.mem_we <= 1'b0;

      if (w_start) begin
        r_win       <= w_win;
        r_we        <= w_we;
        r_in_range  <= w_in_range;
        bus.mem_adr <= w_adr;
        bus.mem_din <= w_din;
        bus.gnt     <= w_grant;
        bus.mem_we  <= w_we & w_in_range;
        bus.err     <= ~w_in_range;
      end

      if (r_state == ST_ACCESS) begin
        r_ptr <= (r_win == c_last) ? '0 : r_win + PW'(1);
        if (!r_we) begin
          // gnt still holds the winner's one-hot during ACCESS.
          bus.rvalid <= bus.gnt;
          bus.rdata  <= r_in_range ? bus.mem_dout : '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                             |
// | Purpose : Self-checking bench for dmem_arbiter. A transaction-level   |
// |           model (pending requests, rotating favourite, shadow memory) |
// |           predicts each cycle's outputs; directed scenarios plus a    |
// |           randomized run share the same model.                        |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int DEPTH = 128;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NREQ  = 2;
  localparam int IXW   = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  logic ram_load;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .NREQ  (NREQ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment memory: combinational read, written on the clock edge.
  logic [DW-1:0] ram [DEPTH];

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA5A5_0000 | DW'(i);
  endfunction

  assign bus.mem_dout = (bus.mem_adr < AW'(DEPTH)) ? ram[bus.mem_adr[IXW-1:0]] : '0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (bus.mem_we && (bus.mem_adr < AW'(DEPTH))) begin
      ram[bus.mem_adr[IXW-1:0]] <= bus.mem_din;
    end
  end

  // ---------------- reference model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit            pend  [NREQ];
  bit            p_we  [NREQ];
  logic [AW-1:0] p_adr [NREQ];
  logic [DW-1:0] p_din [NREQ];
  logic [DW-1:0] shadow [DEPTH];

  int            favour;   // requester searched first at next arbitration
  int            acc_win;  // requester being served this cycle, -1 if none
  bit            acc_we;
  logic [AW-1:0] acc_adr;
  logic [DW-1:0] acc_din;

  logic [NREQ-1:0] exp_gnt, exp_rvalid;
  logic            exp_we, exp_err;
  logic [AW-1:0]   exp_adr;
  logic [DW-1:0]   exp_din, exp_rdata;

  int gl_win[$];
  int gl_cyc[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    favour     = 0;
    acc_win    = -1;
    exp_gnt    = '0;
    exp_rvalid = '0;
    exp_we     = 1'b0;
    exp_err    = 1'b0;
    exp_adr    = '0;
    exp_din    = '0;
    exp_rdata  = '0;
  endtask

  task automatic add_req(input int i, input bit we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] din);
    pend[i]  = 1'b1;
    p_we[i]  = we;
    p_adr[i] = adr;
    p_din[i] = din;
  endtask

  // Expected outputs for the cycle following the next rising edge.
  task automatic predict();
    int  winner;
    int  c;
    bit  in_rng;
    if (acc_win >= 0) begin
      in_rng     = (acc_adr < AW'(DEPTH));
      exp_gnt    = '0;
      exp_we     = 1'b0;
      exp_err    = 1'b0;
      exp_rvalid = '0;
      if (acc_we) begin
        if (in_rng) shadow[acc_adr[IXW-1:0]] = acc_din;
      end else begin
        exp_rvalid = NREQ'(1) << acc_win;
        exp_rdata  = in_rng ? shadow[acc_adr[IXW-1:0]] : '0;
      end
      favour  = (acc_win + 1) % NREQ;
      acc_win = -1;
    end else begin
      exp_rvalid = '0;
      winner     = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (favour + k) % NREQ;
        if (winner < 0 && pend[c]) winner = c;
      end
      if (winner >= 0) begin
        acc_win = winner;
        acc_we  = p_we[winner];
        acc_adr = p_adr[winner];
        acc_din = p_din[winner];
        in_rng  = (acc_adr < AW'(DEPTH));
        exp_gnt = NREQ'(1) << winner;
        exp_we  = acc_we && in_rng;
        exp_err = !in_rng;
        exp_adr = acc_adr;
        exp_din = acc_din;
      end else begin
        exp_gnt = '0;
        exp_we  = 1'b0;
        exp_err = 1'b0;
      end
    end
  endtask

  // Drive current requests, advance one clock, compare at the falling edge.
  task automatic cycle();
    int w;
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]               = pend[i];
      bus.we_i[i]              = p_we[i];
      bus.adr_i[i*AW +: AW]    = p_adr[i];
      bus.din_i[i*DW +: DW]    = p_din[i];
    end
    predict();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("gnt",    64'(bus.gnt),    64'(exp_gnt));
    chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
    chk("err",    64'(bus.err),    64'(exp_err));
    chk("rvalid", 64'(bus.rvalid), 64'(exp_rvalid));
    if (exp_gnt != '0) begin
      chk("mem_adr", 64'(bus.mem_adr), 64'(exp_adr));
      chk("mem_din", 64'(bus.mem_din), 64'(exp_din));
    end
    if (exp_rvalid != '0) chk("rdata", 64'(bus.rdata), 64'(exp_rdata));
    if (bus.gnt != '0) begin
      w = 99;
      for (int i = NREQ - 1; i >= 0; i--) if (bus.gnt[i]) w = i;
      if ($countones(bus.gnt) != 1) w = 99;
      gl_win.push_back(w);
      gl_cyc.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) pend[i] = 1'b0;
  endtask

  task automatic drive_idle();
    bus.req   = '0;
    bus.we_i  = '0;
    bus.adr_i = '0;
    bus.din_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",    64'(bus.gnt),     64'(0));
    chk("rst_rvalid", 64'(bus.rvalid),  64'(0));
    chk("rst_err",    64'(bus.err),     64'(0));
    chk("rst_mem_we", 64'(bus.mem_we),  64'(0));
    chk("rst_rdata",  64'(bus.rdata),   64'(0));
    chk("rst_adr",    64'(bus.mem_adr), 64'(0));
    chk("rst_din",    64'(bus.mem_din), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    ram_load = 1'b1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    for (int i = 0; i < NREQ; i++) begin
      p_we[i]  = 1'b0;
      p_adr[i] = '0;
      p_din[i] = '0;
    end
    do_reset();
    ram_load = 1'b0;

    // Single write then read-back on the CPU port.
    add_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    cycle();
    cycle();
    add_req(0, 1'b0, 32'd5, 32'h0);
    cycle();
    cycle();
    chk("rd5_data", 64'(bus.rdata), 64'(32'hDEAD_BEEF));
    chk("rd5_ram",  64'(ram[5]),    64'(32'hDEAD_BEEF));

    // Both requesters held high from reset: alternating service.
    do_reset();
    gl_win.delete();
    gl_cyc.delete();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) add_req(i, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
      cycle();
    end
    chk("n_gnt", 64'(gl_win.size()), 64'(4));
    for (int k = 0; k < gl_win.size() && k < 4; k++) begin
      chk("gnt_order", 64'(gl_win[k]), 64'(k % 2));
      if (k > 0) chk("gnt_gap", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'(2));
    end
    for (int n = 0; n < 2; n++) cycle();

    // Out-of-range write and read from requester 1.
    do_reset();
    add_req(1, 1'b0, 32'd3, '0);
    cycle();
    cycle();
    add_req(1, 1'b1, 32'd128, 32'h1234_5678);
    cycle();
    chk("oor_w_err", 64'(bus.err), 64'(1));
    cycle();
    add_req(1, 1'b0, 32'd128, '0);
    cycle();
    chk("oor_r_err", 64'(bus.err), 64'(1));
    cycle();
    chk("oor_r_rv",  64'(bus.rvalid), 64'(2'b10));
    chk("oor_r_dat", 64'(bus.rdata),  64'(0));

    // Reset asserted while a write to word 7 is on the memory bus.
    do_reset();
    add_req(0, 1'b1, 32'd7, 32'h0BAD_F00D);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("rstmid_we",  64'(bus.mem_we), 64'(0));
    chk("rstmid_gnt", 64'(bus.gnt),    64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_ram7", 64'(ram[7]), 64'(init_val(7)));
    do_reset();

    // Back-to-back reads of the first and last words.
    add_req(0, 1'b0, 32'd0, '0);
    cycle();
    add_req(0, 1'b0, 32'd127, '0);
    cycle();
    chk("b2b_d0", 64'(bus.rdata), 64'(init_val(0)));
    cycle();
    cycle();
    chk("b2b_d127", 64'(bus.rdata), 64'(init_val(127)));

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 9) == 0)
            add_req(i, 1'($urandom_range(0, 1)), AW'(DEPTH + $urandom_range(0, 5)), DW'($urandom));
          else
            add_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        end
      end
      cycle();
    end
    for (int n = 0; n < 6; n++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, number of data-memory words.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter NREQ, default 2, number of requesters; index 0 is the CPU port.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NREQ  per-requester access request; held high until the matching gnt.
REQ-008 we_i  input  NREQ  per-requester write enable; 1 = write, 0 = read.
REQ-009 adr_i  input  NREQ*AW  per-requester word address, packed with requester i at bits [i*AW +: AW].
REQ-010 din_i  input  NREQ*DW  per-requester write data, packed with requester i at bits [i*DW +: DW].
REQ-011 gnt  output  NREQ  one-cycle pulse to the winning requester during the memory access cycle.
REQ-012 rvalid  output  NREQ  one-cycle pulse marking rdata valid for a read.
REQ-013 rdata  output  DW  registered read data.
REQ-014 err  output  1  one-cycle pulse for an out-of-range access.
REQ-015 mem_we  output  1  write enable to the memory.
REQ-016 mem_adr  output  AW  address to the memory.
REQ-017 mem_din  output  DW  write data to the memory.
REQ-018 mem_dout  input  DW  combinational read data from the memory.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-020 In IDLE with any req bit high, the block SHALL select one winner round-robin, starting the search at priority pointer ptr.
REQ-021 On that edge, the block SHALL latch the winner index, adr_i, din_i and we_i, and SHALL enter ACCESS.
REQ-022 In IDLE with no req bit high, the block SHALL remain in IDLE with all outputs idle.
REQ-023 In ACCESS, mem_adr and mem_din SHALL carry the latched values and gnt[winner] SHALL be 1.
REQ-024 In ACCESS, mem_we SHALL equal the latched write enable AND (latched address < DEPTH).
REQ-025 ACCESS SHALL last exactly one cycle and then return to IDLE.
REQ-026 On the ACCESS-exit edge, ptr SHALL become (winner+1) mod NREQ.
REQ-027 For a read, rdata SHALL capture mem_dout on the ACCESS-exit edge, and rvalid[winner] SHALL be 1 for the following cycle.
REQ-028 Latency: req seen at edge T, gnt during cycle T+1, rvalid during cycle T+2. Peak throughput is one access per two cycles.
REQ-029 rvalid SHALL overlap IDLE arbitration, so a new request can be latched in the same cycle rvalid is high.
REQ-030 An out-of-range address (>= DEPTH) SHALL suppress the write, load rdata with 0, still pulse gnt (and rvalid for a read), and pulse err together with gnt.
REQ-031 A req deasserted after latching SHALL NOT cancel the access; the access completes.
REQ-032 mem_we, gnt, rvalid and err SHALL be registered outputs with no combinational path from req.
REQ-033 Simultaneous requests SHALL be served in turn; no requester waits more than NREQ accesses.

Reset
REQ-034 rst_n low SHALL force, asynchronously: state=IDLE, ptr=0, mem_we=0, gnt=0, rvalid=0, err=0, rdata=0, mem_adr=0, mem_din=0.
REQ-035 Reset during ACCESS SHALL abort the access, with no write occurring after rst_n falls.
REQ-036 The first arbitration after reset release SHALL favour requester 0.

Structure
REQ-037 Package dmem_arb_pkg SHALL hold the state enumeration and the default DEPTH/AW/DW/NREQ constants.
REQ-038 Sub-module rr_arbiter (inputs req and ptr, output one-hot grant) SHALL be purely combinational; all state stays in dmem_arbiter.

Verification
REQ-039 Single write: req[0]=1, we_i[0]=1, adr 5, din 32'hDEADBEEF -> mem_we=1 and gnt[0]=1 exactly one cycle later; a later read of adr 5 returns 32'hDEADBEEF with rvalid[0] two cycles after req.
REQ-040 Contention: req=2'b11 held continuously from reset -> gnt order 0,1,0,1, with gnt pulses spaced 2 cycles apart.
REQ-041 Out-of-range: requester 1 writes adr 128, then reads adr 128 -> no mem_we pulse on the write; the read returns rdata=0 with err and rvalid[1] pulsed.
REQ-042 Reset mid-access: assert rst_n low during ACCESS of a write to adr 7 -> mem_we falls immediately and memory word 7 is unchanged.
REQ-043 Back-to-back reads: requester 0 reads adr 0 then adr 127 -> rvalid pulses spaced 2 cycles apart with the correct data each time.
